// File: rtl/branch_predictor_gshare.sv
// Gshare (or bimodal when HISTORY_BITS=0) direction predictor with a tagged BTB for IF-stage redirect,
// an IF->ID index register so ID trains the entry that predicted, and debug statistics counters.
module branch_predictor_gshare #(
  parameter int PC_WIDTH     = 32,
  parameter int INDEX_BITS   = 3,
  parameter int HISTORY_BITS = 3,
  parameter int COUNTER_BITS = 2,
  parameter int TAG_BITS     = 8,
  parameter int STAT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   IF_Pc,
  input  logic                  IF_Stall,
  input  logic                  ID_Flush,
  input  logic                  ID_Stall,
  input  logic [PC_WIDTH-1:0]   ID_Pc,
  input  logic                  ID_AttemptBranch,
  input  logic                  ID_BranchTaken,
  input  logic [PC_WIDTH-1:0]   ID_BranchTarget,
  output logic                  IF_BtbHit,
  output logic                  IF_PredictTaken,
  output logic [PC_WIDTH-1:0]   IF_PredictTarget,
  output logic                  ID_PredictBranchTaken,
  output logic                  ID_Mispredict,
  output logic [STAT_WIDTH-1:0] Branch_Count,
  output logic [STAT_WIDTH-1:0] Mispredict_Count
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int HW    = (HISTORY_BITS > 0) ? HISTORY_BITS : 1;
  localparam logic [COUNTER_BITS-1:0] CNT_INIT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);
  localparam logic [COUNTER_BITS-1:0] CNT_MAX  = '1;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_WIDTH-1:0] target;
  } btb_entry_t;

  logic [DEPTH-1:0][COUNTER_BITS-1:0] counter;
  btb_entry_t [DEPTH-1:0]             btb;
  logic [HW-1:0]                      history;
  logic [INDEX_BITS-1:0]              hist_ext, bidx, gidx, id_gidx, id_bidx;
  logic [TAG_BITS-1:0]                if_tag, id_tag;
  logic                               res;
  logic                               unused_ok;

  assign bidx    = IF_Pc[INDEX_BITS+1:2];
  assign if_tag  = IF_Pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign id_bidx = ID_Pc[INDEX_BITS+1:2];
  assign id_tag  = ID_Pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign res     = ID_AttemptBranch & ~ID_Stall;

  generate
    if (HISTORY_BITS > 0) begin : g_hist
      assign hist_ext = INDEX_BITS'(history);
      // Casting the concatenation down to HW drops the oldest outcome.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)      history <= '0;
        else if (res) history <= HW'({history, ID_BranchTaken});
      end
    end else begin : g_bimodal
      assign hist_ext = '0;
      assign history  = '0;
    end
  endgenerate

  assign gidx             = bidx ^ hist_ext;
  assign IF_BtbHit        = btb[bidx].valid && (btb[bidx].tag == if_tag);
  assign IF_PredictTaken  = IF_BtbHit & counter[gidx][COUNTER_BITS-1];
  assign IF_PredictTarget = btb[bidx].target;
  assign ID_Mispredict    = res & (ID_PredictBranchTaken != ID_BranchTaken);
  assign unused_ok        = ^{IF_Pc, ID_Pc, history};

  // IF->ID carries the index used at lookup so training hits the same counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_gidx               <= '0;
      ID_PredictBranchTaken <= 1'b0;
    end else if (ID_Flush) begin
      id_gidx               <= '0;
      ID_PredictBranchTaken <= 1'b0;
    end else if (!IF_Stall) begin
      id_gidx               <= gidx;
      ID_PredictBranchTaken <= IF_PredictTaken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter          <= {DEPTH{CNT_INIT}};
      btb              <= '0;
      Branch_Count     <= '0;
      Mispredict_Count <= '0;
    end else if (res) begin
      if (ID_BranchTaken) begin
        if (counter[id_gidx] != CNT_MAX) counter[id_gidx] <= counter[id_gidx] + 1'b1;
        btb[id_bidx] <= '{valid: 1'b1, tag: id_tag, target: ID_BranchTarget};
      end else if (counter[id_gidx] != '0) begin
        counter[id_gidx] <= counter[id_gidx] - 1'b1;
      end
      Branch_Count <= Branch_Count + 1'b1;
      if (ID_Mispredict) Mispredict_Count <= Mispredict_Count + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Drives a gshare and a bimodal instance with identical stimulus; a table-level model queues
// expected outputs per cycle and an independent monitor pops and compares them.
module tb_branch_predictor_gshare;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0, id_pc = '0, id_tgt = '0;
  logic        if_stall = 1'b0, id_flush = 1'b0, id_stall = 1'b0, id_att = 1'b0, id_tk = 1'b0;

  logic [1:0]       hit, pt, idp, mis;
  logic [1:0][31:0] tgt;
  logic [1:0][15:0] bc, mc;

  always #5 clk = ~clk;

  branch_predictor_gshare u_gshare (
    .clk(clk), .rst(rst), .IF_Pc(if_pc), .IF_Stall(if_stall), .ID_Flush(id_flush),
    .ID_Stall(id_stall), .ID_Pc(id_pc), .ID_AttemptBranch(id_att), .ID_BranchTaken(id_tk),
    .ID_BranchTarget(id_tgt), .IF_BtbHit(hit[0]), .IF_PredictTaken(pt[0]),
    .IF_PredictTarget(tgt[0]), .ID_PredictBranchTaken(idp[0]), .ID_Mispredict(mis[0]),
    .Branch_Count(bc[0]), .Mispredict_Count(mc[0]));

  branch_predictor_gshare #(.HISTORY_BITS(0)) u_bimodal (
    .clk(clk), .rst(rst), .IF_Pc(if_pc), .IF_Stall(if_stall), .ID_Flush(id_flush),
    .ID_Stall(id_stall), .ID_Pc(id_pc), .ID_AttemptBranch(id_att), .ID_BranchTaken(id_tk),
    .ID_BranchTarget(id_tgt), .IF_BtbHit(hit[1]), .IF_PredictTaken(pt[1]),
    .IF_PredictTarget(tgt[1]), .ID_PredictBranchTaken(idp[1]), .ID_Mispredict(mis[1]),
    .Branch_Count(bc[1]), .Mispredict_Count(mc[1]));

  typedef struct {
    int          k;
    logic        hit, pt, idp, mis;
    logic [31:0] tgt;
    int          bc, mc;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: counters as integers in 0..3, "taken" means value >= 2.
  int          hb[2] = '{3, 0};
  int          cnt[2][8];
  int          mhist[2], midg[2], mbc[2], mmc[2];
  bit          midp[2];
  bit          bv[8];
  int          btag[8];
  logic [31:0] btgt[8];

  function automatic int bidx_of(logic [31:0] pc);
    return int'((pc >> 2) % 8);
  endfunction
  function automatic int tag_of(logic [31:0] pc);
    return int'((pc >> 5) % 256);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) cnt[k][i] = 1;
      mhist[k] = 0; midg[k] = 0; midp[k] = 0; mbc[k] = 0; mmc[k] = 0;
    end
    for (int i = 0; i < 8; i++) begin bv[i] = 0; btag[i] = 0; btgt[i] = '0; end
  endtask

  task automatic step(input logic [31:0] ipc, input bit ist, fl, ids,
                      input logic [31:0] dpc, input bit att, tk,
                      input logic [31:0] dtgt, input bit do_rst);
    int  b, g;
    bit  h, r, m;
    int  ng[2];
    bit  npt[2];
    exp_t e;
    @(negedge clk);
    if_pc = ipc; if_stall = ist; id_flush = fl; id_stall = ids;
    id_pc = dpc; id_att = att; id_tk = tk; id_tgt = dtgt;
    if (do_rst) begin
      #1 rst = 1'b1; model_reset();
      #1 rst = 1'b0;
    end else #2;
    b = bidx_of(ipc);
    h = bv[b] && (btag[b] == tag_of(ipc));
    r = att && !ids;
    for (int k = 0; k < 2; k++) begin
      g = b ^ (mhist[k] % (1 << hb[k]));
      ng[k] = g; npt[k] = h && (cnt[k][g] >= 2);
      m = r && (midp[k] != tk);
      e.k = k; e.hit = h; e.pt = npt[k]; e.tgt = btgt[b]; e.idp = midp[k]; e.mis = m;
      e.bc = mbc[k]; e.mc = mmc[k];
      exp_q.push_back(e);
      if (r) begin
        if (tk) cnt[k][midg[k]] = (cnt[k][midg[k]] < 3) ? cnt[k][midg[k]] + 1 : 3;
        else    cnt[k][midg[k]] = (cnt[k][midg[k]] > 0) ? cnt[k][midg[k]] - 1 : 0;
        mhist[k] = ((mhist[k] << 1) | int'(tk)) % (1 << hb[k]);
        mbc[k] = (mbc[k] + 1) % 65536;
        if (m) mmc[k] = (mmc[k] + 1) % 65536;
      end
      if (fl)        begin midg[k] = 0;     midp[k] = 0;      end
      else if (!ist) begin midg[k] = ng[k]; midp[k] = npt[k]; end
    end
    if (r && tk) begin
      b = bidx_of(dpc);
      bv[b] = 1; btag[b] = tag_of(dpc); btgt[b] = dtgt;
    end
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s[inst %0d] got %h expected %h at %0t", nm, k, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("btb_hit",      e.k, 32'(hit[e.k]), 32'(e.hit));
        chk("pred_taken",   e.k, 32'(pt[e.k]),  32'(e.pt));
        chk("pred_target",  e.k, tgt[e.k],      e.tgt);
        chk("id_pred",      e.k, 32'(idp[e.k]), 32'(e.idp));
        chk("mispredict",   e.k, 32'(mis[e.k]), 32'(e.mis));
        chk("branch_count", e.k, 32'(bc[e.k]),  32'(e.bc));
        chk("mispred_count",e.k, 32'(mc[e.k]),  32'(e.mc));
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] pcs[4];
    int sel;
    pcs[0] = 32'h20; pcs[1] = 32'h420; pcs[2] = 32'h24; pcs[3] = 32'h40;
    sel = int'($urandom_range(0, 5));
    return (sel < 4) ? pcs[sel] : ($urandom & 32'h1ffc);
  endfunction

  initial begin : driver
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Asynchronous reset pulse between edges with a lookup of 0x20.
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 1);
    // Train taken at 0x20 -> 0x08 three times, then probe.
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    repeat (3) step(32'h20, 0, 0, 0, 32'h20, 1, 1, 32'h08, 0);
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    // Saturate down with four not-taken resolutions.
    repeat (4) step(32'h20, 0, 0, 0, 32'h20, 1, 0, 32'h0, 0);
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    // History walk T,T,NT then a resolution via the history-indexed entry.
    step(32'h20, 0, 0, 0, 32'h20, 1, 1, 32'h08, 0);
    step(32'h20, 0, 0, 0, 32'h20, 1, 1, 32'h08, 0);
    step(32'h20, 0, 0, 0, 32'h20, 1, 0, 32'h08, 0);
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(32'h20, 0, 0, 0, 32'h20, 1, 1, 32'h08, 0);
    repeat (3) step(32'h20, 0, 0, 0, 32'h20, 1, 1, 32'h08, 0);
    // Stall hold, flush-over-stall, ID stall then release.
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    repeat (3) step(32'h40, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(32'h40, 1, 1, 0, 32'h0, 0, 0, 32'h0, 0);
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    repeat (2) step(32'h20, 0, 0, 1, 32'h20, 1, 0, 32'h0, 0);
    step(32'h20, 0, 0, 0, 32'h20, 1, 0, 32'h0, 0);
    // Tag alias: 0x420 shares index with 0x20 and replaces it when trained.
    step(32'h420, 0, 0, 0, 32'h20, 1, 1, 32'h08, 0);
    step(32'h420, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(32'h420, 0, 0, 0, 32'h420, 1, 1, 32'h100, 0);
    step(32'h20, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    step(32'h420, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0);
    // Randomised traffic with occasional asynchronous resets.
    for (int n = 0; n < 600; n++)
      step(rand_pc(), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) == 0, rand_pc(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom & 32'hfffc, $urandom_range(0, 149) == 0);
    @(negedge clk);
    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised successor to the fixed 3-bit-index, per-PC branch predictor used by the five-stage pipeline. It combines a gshare table of saturating counters (bimodal when `HISTORY_BITS=0`) with a tagged branch target buffer (BTB), so prediction happens in IF instead of ID. The predictor index is pipelined IF→ID, so training in ID hits the same entry that produced the prediction. It also keeps prediction/mispredict statistics counters for the debug path.

## Interface
Parameters:
- `PC_WIDTH`, 32: width of PC and target addresses.
- `INDEX_BITS`, 3: log2 of counter-table depth and BTB depth.
- `HISTORY_BITS`, 3: global history length; 0 selects bimodal mode. Must be ≤ `INDEX_BITS`.
- `COUNTER_BITS`, 2: saturating counter width; must be ≥ 1.
- `TAG_BITS`, 8: BTB tag width. Requires `INDEX_BITS + TAG_BITS + 2 ≤ PC_WIDTH`.
- `STAT_WIDTH`, 16: width of statistics counters.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `IF_Pc`  in  PC_WIDTH  fetch address being looked up.
- `IF_Stall`  in  1  holds the IF→ID prediction register.
- `ID_Flush`  in  1  clears the IF→ID prediction register.
- `ID_Stall`  in  1  suppresses training and statistics.
- `ID_Pc`  in  PC_WIDTH  PC of the instruction in ID.
- `ID_AttemptBranch`  in  1  the instruction in ID is a conditional branch.
- `ID_BranchTaken`  in  1  resolved outcome.
- `ID_BranchTarget`  in  PC_WIDTH  resolved taken target.
- `IF_BtbHit`  out  1  a valid BTB entry's tag matches `IF_Pc`.
- `IF_PredictTaken`  out  1  redirect fetch to `IF_PredictTarget`.
- `IF_PredictTarget`  out  PC_WIDTH  BTB target.
- `ID_PredictBranchTaken`  out  1  registered prediction for the instruction in ID.
- `ID_Mispredict`  out  1  valid resolution disagrees with prediction.
- `Branch_Count`  out  STAT_WIDTH  number of valid resolutions.
- `Mispredict_Count`  out  STAT_WIDTH  number of mispredicts.

## Operation
- Lookup index `bidx = IF_Pc[INDEX_BITS+1:2]`.
- Gshare index `gidx = bidx XOR history`, with history zero-extended to `INDEX_BITS`. In bimodal mode `gidx = bidx`.
- Tag is `IF_Pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2]`.
- `IF_BtbHit` = `valid[bidx]` and the stored tag equals the lookup tag.
- `IF_PredictTaken` = `IF_BtbHit` AND MSB of `counter[gidx]`.
- `IF_PredictTarget` = `target[bidx]`, regardless of hit.
- IF→ID register holds `{ID_gidx, ID_PredictBranchTaken}`:
  - `ID_Flush` loads zero and takes priority over `IF_Stall`.
  - Otherwise, when `IF_Stall=0`, it loads `{gidx, IF_PredictTaken}`.
  - Otherwise it holds.
- A valid resolution is `res = ID_AttemptBranch & ~ID_Stall`. On `res`:
  - `counter[ID_gidx]` saturating-increments if taken, decrements otherwise; range is 0 to 2^COUNTER_BITS−1.
  - `history` shifts left, inserting `ID_BranchTaken` at bit 0; nothing happens when `HISTORY_BITS=0`.
  - If taken, `BTB[ID_Pc bidx]` is written with `{valid=1, ID_Pc tag, ID_BranchTarget}`, replacing any alias.
  - `Branch_Count` increments.
  - If mispredicted, `Mispredict_Count` increments. Both counters wrap modulo 2^STAT_WIDTH.
- `ID_Mispredict = res & (ID_PredictBranchTaken != ID_BranchTaken)`, combinational.
- A not-taken resolution never invalidates a BTB entry.

## Timing
- Lookup outputs are combinational from `IF_Pc` and current state, with zero latency.
- Training becomes visible to lookups the cycle after the `res` edge. There is no same-cycle write-to-read bypass; a simultaneous lookup of the entry being trained sees the old value.
- `ID_PredictBranchTaken` is valid one cycle after the IF lookup, subject to stall/flush.
- Reset, at assertion and regardless of clock or mid-update:
  - every counter = 2^(COUNTER_BITS−1)−1 (weakly not-taken, 01 by default);
  - history = 0, all BTB valid bits = 0, targets and tags = 0;
  - IF→ID register = 0 and both statistics counters = 0.
- Reset values of outputs: `IF_BtbHit=0`, `IF_PredictTaken=0`, `IF_PredictTarget=0`, `ID_PredictBranchTaken=0`, `ID_Mispredict=0`.
- `ID_Stall=1` with `ID_AttemptBranch=1` causes no state change and `ID_Mispredict=0`. The resolution counts once, when the stall drops.

## Test plan
- **Reset:** pulse `rst` asynchronously between edges, with `IF_Pc=0x20` → `IF_BtbHit=0`, `IF_PredictTaken=0`, both counts 0, `ID_PredictBranchTaken=0` immediately.
- **Bimodal train** (`HISTORY_BITS=0`): three taken resolutions at `ID_Pc=0x20`, target `0x08` → counter goes 01→10→11→11.
  - First resolution gives `ID_Mispredict=1`.
  - Afterwards, `IF_Pc=0x20` gives `IF_BtbHit=1`, `IF_PredictTarget=0x08`, `IF_PredictTaken=1`.
- **Saturation:** from 11, four not-taken resolutions → 10, 01, 00, 00.
  - BTB entry stays valid.
  - `IF_PredictTaken=0` after the second.
  - `Mispredict_Count` increments only where the prediction was 1.
- **Gshare indexing** (defaults): resolve taken, taken, not-taken → history = 110; `IF_Pc=0x20` registers `ID_gidx=6`. The next resolution trains counter 6, not counter 0.
- **Stall/flush:** `IF_Stall=1` holds `ID_PredictBranchTaken=1` across 3 cycles.
  - `ID_Flush` together with `IF_Stall` clears it to 0.
  - `ID_AttemptBranch=1` with `ID_Stall=1` for 2 cycles → counts unchanged and `ID_Mispredict=0`; counts +1 when the stall releases.
- **Tag alias:** train taken at `0x20` → `IF_Pc=0x420` (same index, tag differs) gives `IF_BtbHit=0`.
  - A taken resolution at `0x420`, target `0x100`, replaces the entry.
  - After that, `0x20` misses.
